// File: rtl/axi_duth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_duth_pkg
//  Description : Shared AXI constants and the AR queue entry type for the
//                responder blocks. Entry fields are sized to the widest
//                supported configuration. Each block narrows the fields to
//                its own parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_duth_pkg;

    // Burst encodings
    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;
    localparam logic [1:0] c_BURST_RES   = 2'b11;

    // Response encodings
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    // Widest field sizes an entry can carry
    localparam int c_MAX_ADDR_W = 64;
    localparam int c_MAX_ID_W   = 16;
    localparam int c_MAX_USER_W = 16;

    typedef struct packed {
        logic [c_MAX_ID_W-1:0]   tid;
        logic [c_MAX_ADDR_W-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic [c_MAX_USER_W-1:0] user;
    } ar_entry_t;

endpackage : axi_duth_pkg
`default_nettype wire

// File: rtl/axi_duth_r_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_duth_r_responder_if
//  Description : AR/R channel bundle shared by the master and the responder.
//                master : drives ar_valid/ar_* and r_ready
//                slave  : drives ar_ready and r_valid/r_*
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_duth_r_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LEN_WIDTH     = 8,
    parameter int SIZE_WIDTH    = 3,
    parameter int BURST_WIDTH   = 2,
    parameter int AR_TID_WIDTH  = 1,
    parameter int AR_USER_WIDTH = 2,
    parameter int R_USER_WIDTH  = 2,
    parameter int R_DATA_WIDTH  = 64,
    parameter int R_RESP_WIDTH  = 2
) ();

    logic                     ar_valid;
    logic                     ar_ready;
    logic [AR_TID_WIDTH-1:0]  ar_tid;
    logic [ADDRESS_WIDTH-1:0] ar_addr;
    logic [LEN_WIDTH-1:0]     ar_len;
    logic [SIZE_WIDTH-1:0]    ar_size;
    logic [BURST_WIDTH-1:0]   ar_burst;
    logic [AR_USER_WIDTH-1:0] ar_user;

    logic                     r_valid;
    logic                     r_ready;
    logic [AR_TID_WIDTH-1:0]  r_tid;
    logic [R_DATA_WIDTH-1:0]  r_data;
    logic [R_RESP_WIDTH-1:0]  r_resp;
    logic                     r_last;
    logic [R_USER_WIDTH-1:0]  r_user;

    modport master (
        output ar_valid, ar_tid, ar_addr, ar_len, ar_size, ar_burst, ar_user,
        input  ar_ready,
        input  r_valid, r_tid, r_data, r_resp, r_last, r_user,
        output r_ready
    );

    modport slave (
        input  ar_valid, ar_tid, ar_addr, ar_len, ar_size, ar_burst, ar_user,
        output ar_ready,
        output r_valid, r_tid, r_data, r_resp, r_last, r_user,
        input  r_ready
    );

endinterface : axi_duth_r_responder_if
`default_nettype wire

// File: rtl/axi_duth_burst_addr.sv
`default_nettype none
// ============================================================================
//  Module      : axi_duth_burst_addr
//  Description : Combinational next-beat address for FIXED/INCR/WRAP bursts.
//  Ports       : cur_i   - address of the current beat
//                addr_i  - start address of the burst
//                len_i   - burst length minus one
//                size_i  - log2 of bytes per beat
//                burst_i - burst type
//                next_o  - address of the following beat
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_duth_burst_addr
    import axi_duth_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LEN_WIDTH     = 8,
    parameter int SIZE_WIDTH    = 3,
    parameter int BURST_WIDTH   = 2
) (
    input  wire logic [ADDRESS_WIDTH-1:0] cur_i,
    input  wire logic [ADDRESS_WIDTH-1:0] addr_i,
    input  wire logic [LEN_WIDTH-1:0]     len_i,
    input  wire logic [SIZE_WIDTH-1:0]    size_i,
    input  wire logic [BURST_WIDTH-1:0]   burst_i,
    output logic      [ADDRESS_WIDTH-1:0] next_o
);

    logic [ADDRESS_WIDTH-1:0] w_bytes;
    logic [ADDRESS_WIDTH-1:0] w_span;
    logic [ADDRESS_WIDTH-1:0] w_low;

    always_comb begin
        w_bytes = ADDRESS_WIDTH'(1) << size_i;
        w_span  = (ADDRESS_WIDTH'(len_i) + ADDRESS_WIDTH'(1)) << size_i;
        w_low   = addr_i & ~(w_span - ADDRESS_WIDTH'(1));
        next_o  = addr_i;
        case (burst_i)
            BURST_WIDTH'(c_BURST_FIXED): next_o = addr_i;
            // Aligning cur makes beat 1 land on the first aligned slot even
            // for an unaligned start; later beats are already aligned.
            BURST_WIDTH'(c_BURST_INCR):
                next_o = (cur_i & ~(w_bytes - ADDRESS_WIDTH'(1))) + w_bytes;
            // Span is a power of two for legal WRAP lengths, so the modulo
            // reduces to a mask.
            BURST_WIDTH'(c_BURST_WRAP):
                next_o = w_low + ((cur_i + w_bytes - w_low) & (w_span - ADDRESS_WIDTH'(1)));
            default: next_o = addr_i;
        endcase
    end

endmodule : axi_duth_burst_addr
`default_nettype wire

// File: rtl/axi_duth_r_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_duth_r_responder
//  Description : AXI read responder. Queues AR requests in order and returns
//                R bursts with an address-derived byte pattern. Beats at or
//                above ADDR_LIMIT answer SLVERR with zero data.
//  Ports       : clk - rising-edge clock
//                rst - synchronous active-low reset
//                bus - AR/R channel bundle (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_duth_r_responder
    import axi_duth_pkg::*;
#(
    parameter int                     AXI_MODE      = 4,
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     LEN_WIDTH     = 8,
    parameter int                     SIZE_WIDTH    = 3,
    parameter int                     BURST_WIDTH   = 2,
    parameter int                     AR_TID_WIDTH  = 1,
    parameter int                     AR_USER_WIDTH = 2,
    parameter int                     R_USER_WIDTH  = 2,
    parameter int                     R_DATA_WIDTH  = 64,
    parameter int                     R_RESP_WIDTH  = 2,
    parameter logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT  = ADDRESS_WIDTH'(32'h0001_0000),
    parameter int                     AR_FIFO_DEPTH = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    axi_duth_r_responder_if.slave   bus
);

    localparam int c_NBYTES     = R_DATA_WIDTH / 8;
    localparam int c_LANE_SHIFT = $clog2(c_NBYTES);
    localparam int c_PTR_W      = (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
    localparam int c_CNT_W      = $clog2(AR_FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BEAT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // AR queue
    // ------------------------------------------------------------------
    ar_entry_t           fifo_q [AR_FIFO_DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [c_CNT_W-1:0]  count_q, count_d;
    logic                ar_ready_q;
    logic                w_push, w_pop;
    ar_entry_t           w_in, w_head;
    logic                w_unused_head;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(AR_FIFO_DEPTH - 1)) return '0;
        return p + c_PTR_W'(1);
    endfunction

    assign w_push = bus.ar_valid && ar_ready_q;
    assign w_head = fifo_q[rd_ptr_q];
    // Entry fields are wider than this configuration needs; fold the spare
    // bits so they do not read as dangling logic.
    assign w_unused_head = ^w_head;

    always_comb begin
        w_in       = '0;
        w_in.tid   = c_MAX_ID_W'(bus.ar_tid);
        w_in.addr  = c_MAX_ADDR_W'(bus.ar_addr);
        w_in.len   = 8'(bus.ar_len);
        w_in.size  = 3'(bus.ar_size);
        w_in.burst = 2'(bus.ar_burst);
        w_in.user  = c_MAX_USER_W'(bus.ar_user);
        count_d    = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) fifo_q[wr_ptr_q] <= w_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ar_ready_q <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q    <= count_d;
            // Ready looks at the post-edge occupancy, so a full queue never
            // sees a push and a pop re-opens it on the following cycle.
            ar_ready_q <= (count_d < c_CNT_W'(AR_FIFO_DEPTH));
        end
    end

    assign bus.ar_ready = ar_ready_q;

    // ------------------------------------------------------------------
    // Burst engine
    // ------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic [AR_TID_WIDTH-1:0]  tid_q;
    logic [ADDRESS_WIDTH-1:0] addr_q, cur_q, w_next;
    logic [LEN_WIDTH-1:0]     len_q, beat_cnt_q;
    logic [SIZE_WIDTH-1:0]    size_q;
    logic [BURST_WIDTH-1:0]   burst_q;
    logic [AR_USER_WIDTH-1:0] user_q;
    logic                     len_err_q;
    logic                     w_load, w_advance, w_last, w_nempty;
    logic [LEN_WIDTH-1:0]     w_head_len;

    assign w_nempty   = (count_q != '0);
    assign w_last     = (beat_cnt_q == len_q);
    assign w_head_len = LEN_WIDTH'(w_head.len);

    always_comb begin
        state_d   = state_q;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_nempty) begin
                    w_pop   = 1'b1;
                    w_load  = 1'b1;
                    state_d = S_BEAT;
                end
            end
            S_BEAT: begin
                if (bus.r_ready) begin
                    if (!w_last) begin
                        w_advance = 1'b1;
                    end else if (w_nempty) begin
                        // Back-to-back: next burst starts on the very next cycle
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    axi_duth_burst_addr #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH),
        .SIZE_WIDTH    (SIZE_WIDTH),
        .BURST_WIDTH   (BURST_WIDTH)
    ) u_burst_addr (
        .cur_i   (cur_q),
        .addr_i  (addr_q),
        .len_i   (len_q),
        .size_i  (size_q),
        .burst_i (burst_q),
        .next_o  (w_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tid_q      <= '0;
            addr_q     <= '0;
            cur_q      <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            user_q     <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_load) begin
                tid_q      <= AR_TID_WIDTH'(w_head.tid);
                addr_q     <= ADDRESS_WIDTH'(w_head.addr);
                cur_q      <= ADDRESS_WIDTH'(w_head.addr);
                len_q      <= w_head_len;
                beat_cnt_q <= '0;
                size_q     <= SIZE_WIDTH'(w_head.size);
                burst_q    <= BURST_WIDTH'(w_head.burst);
                user_q     <= AR_USER_WIDTH'(w_head.user);
                // AXI3 caps bursts at 16 beats; longer ones are refused
                len_err_q  <= (AXI_MODE == 3) && ((w_head_len >> 4) != '0);
            end else if (w_advance) begin
                cur_q      <= w_next;
                beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // R payload, derived from the current beat registers
    // ------------------------------------------------------------------
    logic                    w_valid, w_err;
    logic [7:0]              w_lane_base;
    logic [R_DATA_WIDTH-1:0] w_pattern;

    assign w_valid     = (state_q == S_BEAT);
    assign w_err       = len_err_q || (cur_q >= ADDR_LIMIT);
    assign w_lane_base = cur_q[7:0] & ~8'(c_NBYTES - 1);

    for (genvar gi = 0; gi < c_NBYTES; gi++) begin : g_lane
        assign w_pattern[8*gi +: 8] = w_lane_base + 8'(gi);
    end

    assign bus.r_valid = w_valid;
    assign bus.r_tid   = tid_q;
    assign bus.r_last  = w_valid && w_last;
    assign bus.r_data  = (w_valid && !w_err) ? w_pattern : '0;
    assign bus.r_resp  = (w_valid && w_err) ? R_RESP_WIDTH'(c_RESP_SLVERR)
                                            : R_RESP_WIDTH'(c_RESP_OKAY);

    if (R_USER_WIDTH >= AR_USER_WIDTH) begin : g_user_ext
        assign bus.r_user = R_USER_WIDTH'(user_q);
    end else begin : g_user_trunc
        assign bus.r_user = user_q[R_USER_WIDTH-1:0];
    end

    // Illegal requests have no defined response; flag them at acceptance.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            assert (bus.ar_burst != BURST_WIDTH'(c_BURST_RES));
            assert (int'(bus.ar_size) <= c_LANE_SHIFT);
            if (bus.ar_burst == BURST_WIDTH'(c_BURST_WRAP)) begin
                assert ((bus.ar_len == LEN_WIDTH'(1)) || (bus.ar_len == LEN_WIDTH'(3)) ||
                        (bus.ar_len == LEN_WIDTH'(7)) || (bus.ar_len == LEN_WIDTH'(15)));
            end
        end
    end

endmodule : axi_duth_r_responder
`default_nettype wire

// File: tb/tb_axi_duth_r_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_duth_r_responder
//  Description : Self-checking bench for axi_duth_r_responder. A beat-level
//                model predicts every R beat and the cycle it may first
//                appear; directed scenarios pin the model with literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_duth_r_responder;

    localparam logic [31:0] c_LIMIT = 32'h0001_0000;

    logic clk;
    logic rst;

    axi_duth_r_responder_if #(
        .ADDRESS_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3), .BURST_WIDTH(2),
        .AR_TID_WIDTH(1), .AR_USER_WIDTH(2), .R_USER_WIDTH(2),
        .R_DATA_WIDTH(64), .R_RESP_WIDTH(2)
    ) bus ();

    axi_duth_r_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          avail;
        logic        tid;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [1:0]  user;
    } beat_t;

    beat_t model_q[$];
    beat_t got_q[$];
    beat_t bt;
    logic  prev_rst_low = 1'b0;
    logic  armed        = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- model ----------------
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                              input int size, input logic [1:0] burst,
                                              input int n);
        logic [31:0] b, s, low, cur;
        b   = 32'd1 << size;
        s   = b * 32'(len + 1);
        low = a & ~(s - 32'd1);
        case (burst)
            2'b00: return a;
            2'b01: return (n == 0) ? a : ((a & ~(b - 32'd1)) + b * 32'(n));
            default: begin
                cur = a;
                for (int k = 0; k < n; k++) cur = low + ((cur + b - low) % s);
                return cur;
            end
        endcase
    endfunction

    function automatic logic [63:0] pattern(input logic [31:0] ba);
        logic [31:0] al;
        logic [63:0] d;
        al = ba & ~32'd7;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'(al + 32'(i));
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (armed) begin
            if (prev_rst_low) begin
                check("rst_ar_ready", bus.ar_ready, 0);
                check("rst_r_last",   bus.r_last, 0);
                check("rst_r_data",   bus.r_data, 0);
                check("rst_r_resp",   bus.r_resp, 0);
                check("rst_r_tid",    bus.r_tid, 0);
                check("rst_r_user",   bus.r_user, 0);
            end
            check("r_valid", bus.r_valid,
                  (model_q.size() > 0 && model_q[0].avail <= cyc) ? 1 : 0);
            if (bus.r_valid && model_q.size() > 0) begin
                check("r_tid",  bus.r_tid,  model_q[0].tid);
                check("r_data", bus.r_data, model_q[0].data);
                check("r_resp", bus.r_resp, model_q[0].resp);
                check("r_last", bus.r_last, model_q[0].last);
                check("r_user", bus.r_user, model_q[0].user);
            end
            if (rst && bus.r_valid && bus.r_ready && model_q.size() > 0) begin
                bt      = model_q.pop_front();
                bt.data = bus.r_data;
                bt.resp = bus.r_resp;
                bt.last = bus.r_last;
                bt.tid  = bus.r_tid;
                got_q.push_back(bt);
            end
            if (rst && bus.ar_valid && bus.ar_ready) begin
                for (int n = 0; n <= int'(bus.ar_len); n++) begin
                    logic [31:0] ba;
                    ba = beat_addr(bus.ar_addr, int'(bus.ar_len), int'(bus.ar_size),
                                   bus.ar_burst, n);
                    bt.avail = cyc + 2;
                    bt.tid   = bus.ar_tid;
                    bt.user  = bus.ar_user;
                    bt.last  = (n == int'(bus.ar_len));
                    bt.resp  = (ba >= c_LIMIT) ? 2'b10 : 2'b00;
                    bt.data  = (ba >= c_LIMIT) ? 64'd0 : pattern(ba);
                    model_q.push_back(bt);
                end
            end
            if (!rst) model_q.delete();
        end
        armed        = 1'b1;
        prev_rst_low = !rst;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_ar(input int tid, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input int user);
        logic done;
        done         = 1'b0;
        bus.ar_tid   = 1'(tid);
        bus.ar_addr  = addr;
        bus.ar_len   = 8'(len);
        bus.ar_size  = 3'(size);
        bus.ar_burst = burst;
        bus.ar_user  = 2'(user);
        bus.ar_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.ar_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.ar_valid = 1'b0;
        if (!done) fail_now("ar_handshake");
    endtask

    task automatic wait_beats(input int n, input logic toggle);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (got_q.size() >= n) ok = 1'b1;
            else if (toggle) bus.r_ready = ~bus.r_ready;
        end
        if (!ok) fail_now("beat_wait");
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b0;
        bus.ar_valid = 0; bus.ar_tid = 0; bus.ar_addr = 0; bus.ar_len = 0;
        bus.ar_size = 0; bus.ar_burst = 0; bus.ar_user = 0; bus.r_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ar_ready", bus.ar_ready, 0);
        check("reset_r_valid",  bus.r_valid, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ar_ready_after_reset", bus.ar_ready, 1);

        // INCR 0x100, len 3, size 3
        @(posedge clk); #1 bus.r_ready = 1'b1;
        got_q.delete();
        send_ar(1, 32'h100, 3, 3, 2'b01, 2);
        @(negedge clk);
        @(negedge clk);
        check("incr_latency_valid", bus.r_valid, 1);
        check("incr_latency_data",  bus.r_data, 64'h0706050403020100);
        wait_beats(4, 1'b0);
        check("incr_b1", got_q[1].data, 64'h0f0e0d0c0b0a0908);
        check("incr_b2", got_q[2].data, 64'h1716151413121110);
        check("incr_b3", got_q[3].data, 64'h1f1e1d1c1b1a1918);
        check("incr_b2_last", got_q[2].last, 0);
        check("incr_b3_last", got_q[3].last, 1);
        check("incr_resp", got_q[3].resp, 0);

        // WRAP 0x118, len 3, size 3
        got_q.delete();
        send_ar(0, 32'h118, 3, 3, 2'b10, 1);
        wait_beats(4, 1'b0);
        check("wrap_b0", got_q[0].data, 64'h1f1e1d1c1b1a1918);
        check("wrap_b1", got_q[1].data, 64'h0706050403020100);
        check("wrap_b3", got_q[3].data, 64'h1716151413121110);

        // FIXED 0x204, len 2, size 2
        got_q.delete();
        send_ar(1, 32'h204, 2, 2, 2'b00, 3);
        wait_beats(3, 1'b0);
        check("fixed_b2", got_q[2].data, 64'h0706050403020100);
        check("fixed_b1_last", got_q[1].last, 0);
        check("fixed_b2_last", got_q[2].last, 1);

        // INCR len 7 with r_ready toggling 1,0,1,0
        got_q.delete();
        send_ar(0, 32'h0, 7, 3, 2'b01, 0);
        wait_beats(8, 1'b1);
        check("toggle_b7", got_q[7].data, 64'h3f3e3d3c3b3a3938);
        check("toggle_b7_last", got_q[7].last, 1);
        bus.r_ready = 1'b1;

        // Three back-to-back ARs with the master stalled
        repeat (2) @(posedge clk);
        #1 bus.r_ready = 1'b0;
        got_q.delete();
        send_ar(0, 32'h300, 1, 3, 2'b01, 0);
        send_ar(1, 32'h340, 1, 3, 2'b01, 1);
        send_ar(0, 32'h380, 1, 3, 2'b01, 2);
        @(negedge clk);
        check("queue_full_ar_ready", bus.ar_ready, 0);
        @(posedge clk); #1 bus.r_ready = 1'b1;
        wait_beats(6, 1'b0);
        check("order_tid1", got_q[2].tid, 1);
        check("order_tid2", got_q[4].tid, 0);
        check("order_data2", got_q[4].data, 64'h8786858483828180);
        @(negedge clk);
        check("ar_ready_reopened", bus.ar_ready, 1);

        // Crossing ADDR_LIMIT
        @(posedge clk); #1;
        got_q.delete();
        send_ar(1, c_LIMIT - 32'd8, 1, 3, 2'b01, 1);
        wait_beats(2, 1'b0);
        check("limit_b0_resp", got_q[0].resp, 0);
        check("limit_b0_data", got_q[0].data, 64'hfffefdfcfbfaf9f8);
        check("limit_b1_resp", got_q[1].resp, 2);
        check("limit_b1_data", got_q[1].data, 0);

        // Reset in the middle of a burst with another burst queued
        got_q.delete();
        send_ar(0, 32'h400, 7, 3, 2'b01, 0);
        send_ar(1, 32'h800, 3, 3, 2'b01, 0);
        wait_beats(2, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("abort_r_valid", bus.r_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_queue_empty", bus.r_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        fail_now("global_watchdog");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_axi_duth_r_responder
`default_nettype wire
